// File: rtl/instr_decode_stage.sv
// Decode stage: splits 16-bit instructions into fields and control strobes and
// registers them toward execute behind a one-entry skid buffer with load-use stall.
module instr_decode_stage #(
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned XLEN        = 32
) (
    input  logic                   clk_i,
    input  logic                   arst_ni,
    input  logic                   flush_i,
    input  logic                   if_valid_i,
    output logic                   if_ready_o,
    input  logic [INSTR_WIDTH-1:0] if_instr_i,
    input  logic [XLEN-1:0]        if_pc_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [3:0]             id_func_o,
    output logic [3:0]             id_rd_o,
    output logic [3:0]             id_rs1_o,
    output logic [3:0]             id_rs2_o,
    output logic [XLEN-1:0]        id_imm_o,
    output logic [XLEN-1:0]        id_pc_o,
    output logic                   id_rf_we_o,
    output logic                   id_mem_rd_o,
    output logic                   id_mem_wr_o,
    output logic                   id_illegal_o
);

    typedef enum logic [3:0] {
        F_ADDI  = 4'h1,
        F_SUB   = 4'h2,
        F_ADD   = 4'h3,
        F_AND   = 4'h4,
        F_OR    = 4'h5,
        F_XOR   = 4'h6,
        F_NOT   = 4'h7,
        F_STORE = 4'hA,
        F_LOAD  = 4'hB,
        F_SLL   = 4'hC,
        F_SLR   = 4'hD,
        F_SLLI  = 4'hE,
        F_SLRI  = 4'hF
    } func_t;

    typedef struct packed {
        logic [3:0]      func;
        logic [3:0]      rd;
        logic [3:0]      rs1;
        logic [3:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            rf_we;
        logic            mem_rd;
        logic            mem_wr;
        logic            illegal;
        logic            use_rs1;
        logic            use_rs2;
    } bundle_t;

    bundle_t    dec;
    bundle_t    or_q, or_d, sk_q, sk_d;
    logic       or_valid_q, or_valid_d;
    logic       sk_valid_q, sk_valid_d;
    logic       lu_pend_q, lu_pend_d;
    logic [3:0] lu_rd_q, lu_rd_d;
    logic       hazard, handoff, accept;

    // Field extraction and control decode of the incoming word.
    always_comb begin
        dec      = '0;
        dec.func = if_instr_i[3:0];
        dec.rd   = if_instr_i[7:4];
        dec.rs1  = if_instr_i[11:8];
        dec.rs2  = if_instr_i[15:12];
        dec.pc   = if_pc_i;
        case (if_instr_i[3:0])
            F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLL, F_SLR: begin
                dec.rf_we   = 1'b1;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
            end
            F_STORE: begin
                dec.mem_wr  = 1'b1;
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
            end
            F_NOT: begin
                dec.rf_we   = 1'b1;
                dec.use_rs1 = 1'b1;
            end
            F_ADDI: begin
                dec.rf_we   = 1'b1;
                dec.use_rs1 = 1'b1;
                dec.imm     = {{(XLEN-4){if_instr_i[15]}}, if_instr_i[15:12]};
            end
            F_SLLI, F_SLRI: begin
                dec.rf_we   = 1'b1;
                dec.use_rs1 = 1'b1;
                dec.imm     = {{(XLEN-4){1'b0}}, if_instr_i[15:12]};
            end
            F_LOAD: begin
                dec.rf_we   = 1'b1;
                dec.mem_rd  = 1'b1;
                dec.use_rs1 = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Stall the output entry for one cycle if it consumes a just-issued load result.
    assign hazard = lu_pend_q & or_valid_q &
                    ((or_q.use_rs1 & (or_q.rs1 == lu_rd_q)) |
                     (or_q.use_rs2 & (or_q.rs2 == lu_rd_q)));

    assign id_valid_o = or_valid_q & ~hazard;
    assign handoff    = id_valid_o & id_ready_i;
    assign if_ready_o = ~sk_valid_q;
    assign accept     = if_valid_i & if_ready_o;

    // Next-state for output register, skid entry and load-use tracker.
    always_comb begin
        or_d       = or_q;
        or_valid_d = or_valid_q;
        sk_d       = sk_q;
        sk_valid_d = sk_valid_q;
        lu_pend_d  = 1'b0;
        lu_rd_d    = lu_rd_q;
        if (flush_i) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else begin
            if (handoff) begin
                lu_pend_d = or_q.mem_rd;
                lu_rd_d   = or_q.rd;
            end
            if (!or_valid_q || handoff) begin
                if (sk_valid_q) begin
                    or_d       = sk_q;
                    or_valid_d = 1'b1;
                    sk_valid_d = 1'b0;
                end else if (accept) begin
                    or_d       = dec;
                    or_valid_d = 1'b1;
                end else begin
                    or_valid_d = 1'b0;
                end
            end else if (accept) begin
                sk_d       = dec;
                sk_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            or_q       <= '0;
            or_valid_q <= 1'b0;
            sk_q       <= '0;
            sk_valid_q <= 1'b0;
            lu_pend_q  <= 1'b0;
            lu_rd_q    <= 4'h0;
        end else begin
            or_q       <= or_d;
            or_valid_q <= or_valid_d;
            sk_q       <= sk_d;
            sk_valid_q <= sk_valid_d;
            lu_pend_q  <= lu_pend_d;
            lu_rd_q    <= lu_rd_d;
        end
    end

    assign id_func_o    = or_q.func;
    assign id_rd_o      = or_q.rd;
    assign id_rs1_o     = or_q.rs1;
    assign id_rs2_o     = or_q.rs2;
    assign id_imm_o     = or_q.imm;
    assign id_pc_o      = or_q.pc;
    assign id_rf_we_o   = or_q.rf_we;
    assign id_mem_rd_o  = or_q.mem_rd;
    assign id_mem_wr_o  = or_q.mem_wr;
    assign id_illegal_o = or_q.illegal;

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Decode stage of the simple processor pipeline. Accepts 16-bit instructions from fetch over a valid/ready handshake and splits them into function code, register indices, immediate and control strobes. Registers the result toward execute behind a one-entry skid buffer. Inserts a one-cycle bubble on load-use hazards and supports a synchronous flush from branch/exception logic.

## Interface
- INSTR_WIDTH, 16, instruction width (format below is fixed for 16)
- XLEN, 32, width of PC and immediate outputs
- clk_i  in  1  clock, rising edge
- arst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush of all stage contents
- if_valid_i  in  1  fetch presents an instruction
- if_ready_o  out  1  stage can accept this cycle
- if_instr_i  in  INSTR_WIDTH  instruction word
- if_pc_i  in  XLEN  PC of instruction
- id_valid_o  out  1  decoded instruction valid toward execute
- id_ready_i  in  1  execute accepts
- id_func_o  out  4  func_t code, copied from instr[3:0]
- id_rd_o / id_rs1_o / id_rs2_o  out  4 each  instr[7:4] / instr[11:8] / instr[15:12]
- id_imm_o  out  XLEN  immediate
- id_pc_o  out  XLEN  PC of decoded instruction
- id_rf_we_o  out  1  instruction writes rd
- id_mem_rd_o / id_mem_wr_o  out  1 each  LOAD / STORE
- id_illegal_o  out  1  func not in func_t

## Operation
- Format: [3:0] func, [7:4] rd, [11:8] rs1, [15:12] rs2/imm4.
- Immediate:
  - ADDI: sign-extended imm4 (e.g. 4'hF -> 32'hFFFF_FFFF).
  - SLLI/SLRI: zero-extended imm4.
  - All other codes: 0.
- Control strobes:
  - rf_we=1 for every legal code except STORE.
  - mem_rd=1 only for LOAD; mem_wr=1 only for STORE.
- Illegal codes (4'b0000, 4'b1000, 4'b1001): illegal=1, rf_we=mem_rd=mem_wr=0; the instruction still flows through for trap handling.
- Source usage:
  - ADD, SUB, AND, OR, XOR, SLL, SLR, STORE read rs1 and rs2.
  - NOT, ADDI, SLLI, SLRI, LOAD read rs1 only.
  - Illegal codes read nothing.
- Storage: output register (OR) plus one skid entry (SK), each holding the full decoded bundle and a valid bit.
  - if_ready_o = ~SK.valid.
  - Accept when if_valid_i & if_ready_o.
  - The accepted instruction goes to OR if OR is empty or is handed off this cycle; otherwise it goes to SK.
  - On OR handoff with SK valid, SK moves to OR.
- Load-use hazard:
  - lu_pend (1 bit) and lu_rd (4 bits) are set on a handoff of a LOAD with lu_rd=rd.
  - Both clear on the next cycle, unconditionally.
  - While lu_pend=1 and OR holds an instruction that reads lu_rd, id_valid_o=0 and OR holds.
- Handoff = id_valid_o & id_ready_i.
- Flush: OR.valid, SK.valid and lu_pend clear at the next edge. An instruction accepted in the flush cycle is discarded. Flush has priority over accept and handoff.
- Reset: all valid bits, lu_pend and all outputs are 0; if_ready_o=1 once the skid is empty (immediately).

## Timing
- Latency: accept at edge N -> id_valid_o=1 after edge N (same cycle N+1) when OR was free.
- Throughput: 1 instruction/cycle with id_ready_i held high and no hazards.
- Backpressure:
  - id_ready_i=0 with OR full absorbs one more instruction into SK.
  - if_ready_o drops in the cycle after SK fills.
  - No instruction is lost or duplicated.
- While id_valid_o=1 and id_ready_i=0, all id_* outputs stay stable.
- id_* payload outputs are don't-care when id_valid_o=0. Payload registers are not cleared on handoff.
- Load-use bubble costs exactly one cycle. A second, non-dependent instruction never waits.
- Reset deassertion mid-stream: the stage starts empty and ignores any if_valid_i seen during reset.

## Test plan
- Stream ADD(rd=1,rs1=2,rs2=3)=16'h3213, ADDI rd=4 imm=F (16'hF041), STORE (16'h321A), with id_ready_i=1 -> three consecutive id_valid_o pulses.
  - ADD: func=3, rf_we=1.
  - ADDI: imm=32'hFFFF_FFFF.
  - STORE: mem_wr=1, rf_we=0.
- SLLI with imm=4'hC -> id_imm_o=32'h0000_000C. Opcode 4'b1000 -> id_illegal_o=1 with all strobes 0.
- Hold id_ready_i=0 for 5 cycles while fetch streams 4 instructions -> 2 captured and if_ready_o=0 from the cycle after the 2nd accept. After release, all 4 instructions emerge in order, with no gap after the first.
- LOAD rd=5 followed by ADD rs1=5, id_ready_i=1 -> one cycle with id_valid_o=0 between them. LOAD rd=5 followed by ADD rs1=6 -> no bubble.
- With OR and SK full, assert flush_i and if_valid_i for one cycle -> id_valid_o=0 and if_ready_o=1 next cycle, and the flushed-cycle instruction never appears.
- Drop arst_ni asynchronously mid-stream -> id_valid_o=0 immediately. After release, the first accepted instruction appears after 1 cycle.
